comb_sweep_driver: RTL and testbench
====================================

Name: comb_sweep_driver

Overview:
- Sequential stimulus/response stage wrapped around the 3-input combinational block `comb`.
- Drives `comb`'s X/Y/Z inputs through every input combination and holds each vector for a fixed number of cycles.
- Samples `comb`'s Out and builds the observed truth table.
- Compares the observed table against an expected table and reports a pass/fail summary with a start/done handshake. This replaces hand-written delay-sequenced stimulus.

Parameters:
- N_IN, 3, number of DUT inputs; the table width is TW = 2**N_IN.
- HOLD, 2, cycles each vector is held; must be >= 2.
- SETTLE, 1, cycle offset within a hold window at which dut_out is sampled; must satisfy 0 <= SETTLE < HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a sweep; sampled only in IDLE
- expected  input  TW  expected truth table, bit i = Out for vector i; latched on accepted start
- dut_out  input  1  Out from comb
- vec_out  output  N_IN  vector driven to comb; bit N_IN-1 = X, bit 0 = Z
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when the sweep completes
- table_out  output  TW  observed truth table
- mismatch  output  1  sticky: at least one bit differed in the last sweep
- mismatch_idx  output  N_IN  index of the first differing vector
- err_count  output  N_IN+1  number of differing vectors, 0..TW

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state = IDLE.
  - vec_out, busy, done, table_out, mismatch, mismatch_idx, err_count and the internal hold counter and latched expected value all go to 0.
  - Applies immediately, including mid-sweep.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: on an edge where start=1.
  - Latch expected.
  - Clear table_out, mismatch, mismatch_idx, err_count.
  - Set vec_out = first vector, hold_cnt = 0, busy = 1.
- RUN, each cycle:
  - hold_cnt increments.
  - When hold_cnt == SETTLE:
    - Write dut_out into table_out[vec_out].
    - If dut_out != expected_q[vec_out], increment err_count.
    - If that is the first error, set mismatch = 1 and mismatch_idx = vec_out.
  - When hold_cnt == HOLD-1:
    - If vec_out is the last vector, go to DONE.
    - Otherwise advance vec_out and set hold_cnt = 0.
- DONE: done = 1 and busy = 0 for exactly one cycle, then return to IDLE.
- Results persist in IDLE until the next accepted start.
- vec_out holds its last value in DONE/IDLE.
- Latency: with start sampled at edge 0, done is high during the cycle following edge TW*HOLD+1. For N_IN=3, HOLD=2 that is edge 17.
- start while busy or in DONE is ignored; it is not queued.
- A start held high continuously restarts a sweep on the first IDLE cycle after DONE.
- Changes to expected during RUN have no effect.
- err_count saturation is not needed; its width covers TW.
- dut_out is sampled synchronously. The DUT is combinational, so a value sampled at SETTLE >= 0 reflects the current vec_out.

Optional Feature:
- Macro: COMB_SWEEP_GRAY_EN.
  - Defined: vectors are applied in Gray-code order (gray(k) = k ^ (k>>1), k = 0..TW-1), so exactly one input toggles per step. The sequence for N_IN=3 is 0,1,3,2,6,7,5,4. Table bits and mismatch_idx are still indexed by the vector value, not by step number. The sweep ends after step k = TW-1.
  - Not defined: binary ascending order 0..TW-1.
- Latency and all other behaviour are identical in both builds.

Decomposition:
- Shared package comb_sweep_pkg holds:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The TW width function.
  - The gray conversion function.
- Natural sub-module: sweep_vec_gen. It is a step counter plus hold counter with an optional Gray mapping, with outputs vec_out and last_step. The FSM, compare logic and table register stay in comb_sweep_driver.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with start=1 -> all outputs 0, no sweep begins until rst_n=1.
- Matching sweep: comb = majority(X,Y,Z), expected=8'hE8, HOLD=2; pulse start at edge 0 -> vec_out steps 0..7, two cycles each; done pulse at edge 17; table_out=8'hE8, mismatch=0, err_count=0.
- Single mismatch: same DUT, expected=8'hE9 -> table_out=8'hE8, mismatch=1, mismatch_idx=0, err_count=1.
- Stuck DUT: dut_out tied 0, expected=8'hFF -> table_out=8'h00, err_count=8, mismatch_idx=0.
- Control corners:
  - start pulsed at edge 5 during a sweep -> ignored, done still at edge 17.
  - rst_n pulsed low while vec_out=4 -> outputs 0 immediately.
  - A following start sweeps from vector 0 and gives fresh results.
- Gray build (COMB_SWEEP_GRAY_EN) with the majority DUT -> vec_out sequence 0,1,3,2,6,7,5,4; table_out=8'hE8; done at edge 17.

Source files
------------

// File: rtl/comb_sweep_pkg.sv
// Shared encodings and helpers for the comb sweep driver and its vector generator.
// The Gray helper is only used when COMB_SWEEP_GRAY_EN is defined.
package comb_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Truth-table width for an n-input block.
    function automatic int tw(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic logic [31:0] gray(input logic [31:0] k);
        return k ^ (k >> 1);
    endfunction

endpackage

// File: rtl/sweep_vec_gen.sv
// Step counter plus hold counter producing the stimulus vector and sample/advance strobes.
// Build option COMB_SWEEP_GRAY_EN maps the step number through a Gray code.
module sweep_vec_gen
    import comb_sweep_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int HOLD   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            run_i,
    output logic [N_IN-1:0] vec_o,
    output logic            sample_o,
    output logic            hold_end_o,
    output logic            last_step_o
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [N_IN-1:0] step_q, step_d;
    logic [HW-1:0]   hold_q, hold_d;

    assign sample_o    = (hold_q == HW'(SETTLE));
    assign hold_end_o  = (hold_q == HW'(HOLD - 1));
    assign last_step_o = (step_q == {N_IN{1'b1}});

`ifdef COMB_SWEEP_GRAY_EN
    assign vec_o = N_IN'(gray(32'(step_q)));
`else
    assign vec_o = step_q;
`endif

    always_comb begin
        step_d = step_q;
        hold_d = hold_q;
        if (load_i) begin
            step_d = '0;
            hold_d = '0;
        end else if (run_i) begin
            if (hold_end_o) begin
                hold_d = '0;
                // The final step is kept so vec_o holds its last value afterwards.
                if (!last_step_o) begin
                    step_d = step_q + N_IN'(1);
                end
            end else begin
                hold_d = hold_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
            hold_q <= '0;
        end else begin
            step_q <= step_d;
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/comb_sweep_driver.sv
// Sweeps a combinational block through every input vector, records its truth table and
// compares it to an expected table; Gray-order sweep when COMB_SWEEP_GRAY_EN is defined.
module comb_sweep_driver
    import comb_sweep_pkg::*;
#(
    parameter int  N_IN   = 3,
    parameter int  HOLD   = 2,
    parameter int  SETTLE = 1,
    localparam int TW     = tw(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [TW-1:0]   expected,
    input  logic            dut_out,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic [TW-1:0]   table_out,
    output logic            mismatch,
    output logic [N_IN-1:0] mismatch_idx,
    output logic [N_IN:0]   err_count
);

    state_e          state_q, state_d;
    logic [TW-1:0]   exp_q, exp_d;
    logic [TW-1:0]   table_q, table_d;
    logic            mism_q, mism_d;
    logic [N_IN-1:0] midx_q, midx_d;
    logic [N_IN:0]   errc_q, errc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic load, run, sample, hold_end, last_step;

    sweep_vec_gen #(
        .N_IN   (N_IN),
        .HOLD   (HOLD),
        .SETTLE (SETTLE)
    ) u_vec_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .run_i       (run),
        .vec_o       (vec_out),
        .sample_o    (sample),
        .hold_end_o  (hold_end),
        .last_step_o (last_step)
    );

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        table_d = table_q;
        mism_d  = mism_q;
        midx_d  = midx_q;
        errc_d  = errc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        run     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    exp_d   = expected;
                    table_d = '0;
                    mism_d  = 1'b0;
                    midx_d  = '0;
                    errc_d  = '0;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end
            end
            RUN: begin
                run = 1'b1;
                if (sample) begin
                    table_d[vec_out] = dut_out;
                    if (dut_out != exp_q[vec_out]) begin
                        errc_d = errc_q + (N_IN+1)'(1);
                        if (!mism_q) begin
                            mism_d = 1'b1;
                            midx_d = vec_out;
                        end
                    end
                end
                if (hold_end && last_step) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                // done is registered on the way out of DONE, one edge after the last sample.
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            exp_q   <= '0;
            table_q <= '0;
            mism_q  <= 1'b0;
            midx_q  <= '0;
            errc_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            table_q <= table_d;
            mism_q  <= mism_d;
            midx_q  <= midx_d;
            errc_q  <= errc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign table_out    = table_q;
    assign mismatch     = mism_q;
    assign mismatch_idx = midx_q;
    assign err_count    = errc_q;

endmodule

// File: tb/tb_comb_sweep_driver.sv
// Directed bench for comb_sweep_driver with a majority-function (or stuck-at-0) comb model.
// Also valid with COMB_SWEEP_GRAY_EN defined: the expected vector order follows the build.
module tb_comb_sweep_driver;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] expected;
    logic       dut_out;
    logic [2:0] vec_out;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic       mismatch;
    logic [2:0] mismatch_idx;
    logic [3:0] err_count;
    bit         stuck;

    int checks   = 0;
    int failures = 0;

    comb_sweep_driver #(.N_IN(3), .HOLD(2), .SETTLE(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .expected     (expected),
        .dut_out      (dut_out),
        .vec_out      (vec_out),
        .busy         (busy),
        .done         (done),
        .table_out    (table_out),
        .mismatch     (mismatch),
        .mismatch_idx (mismatch_idx),
        .err_count    (err_count)
    );

    // comb under test: majority(X,Y,Z), or stuck at 0
    assign dut_out = stuck ? 1'b0 :
                     ((vec_out[2] & vec_out[1]) | (vec_out[2] & vec_out[0]) | (vec_out[1] & vec_out[0]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] exp_in;
        bit         stuck;
        logic [7:0] tab;
        bit         mism;
        logic [2:0] idx;
        logic [3:0] err;
    } vec_t;

    vec_t tv[6];

    function automatic logic [2:0] seq_vec(input int k);
        logic [2:0] kk;
        kk = 3'(k);
`ifdef COMB_SWEEP_GRAY_EN
        return kk ^ (kk >> 1);
`else
        return kk;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Starts a sweep and follows it to done. At edge 'poke' a stray start pulse and a
    // change of expected are injected. Returns the edge at which done was seen (-1 if never).
    task automatic run_sweep(input logic [7:0] exp_in, input int poke,
                             output int done_edge, output bit vec_ok, output bit pulse_ok);
        done_edge = -1;
        vec_ok    = 1'b1;
        expected  = exp_in;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (busy !== 1'b1 || vec_out !== 3'd0) vec_ok = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            if (e == poke) begin
                start    = 1'b1;
                expected = ~exp_in;
            end
            @(posedge clk);
            #1;
            if (e == poke) start = 1'b0;
            if (vec_out !== seq_vec((e / 2 > 7) ? 7 : e / 2)) vec_ok = 1'b0;
            if (done === 1'b1) begin
                done_edge = e;
                break;
            end
        end
        @(posedge clk);
        #1;
        pulse_ok = (done === 1'b0) && (busy === 1'b0);
    endtask

    int  de;
    bit  vok, pok;
    int  guard;

    initial begin
        tv[0] = '{8'hE8, 1'b0, 8'hE8, 1'b0, 3'd0, 4'd0};
        tv[1] = '{8'hE9, 1'b0, 8'hE8, 1'b1, 3'd0, 4'd1};
        tv[2] = '{8'hFF, 1'b1, 8'h00, 1'b1, 3'd0, 4'd8};
        tv[3] = '{8'h00, 1'b0, 8'hE8, 1'b1, 3'd3, 4'd4};
        tv[4] = '{8'h68, 1'b0, 8'hE8, 1'b1, 3'd7, 4'd1};
        tv[5] = '{8'h17, 1'b0, 8'hE8, 1'b1, 3'd0, 4'd8};

        rst_n    = 1'b0;
        start    = 1'b1;
        expected = 8'hE8;
        stuck    = 1'b0;

        // reset held with start asserted
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_outputs", {vec_out, busy, done, table_out, mismatch, mismatch_idx, err_count}, 0);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_reset_busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            stuck = tv[i].stuck;
            run_sweep(tv[i].exp_in, (i == 0) ? 5 : -1, de, vok, pok);
            chk($sformatf("v%0d_done_edge", i), de, 17);
            chk($sformatf("v%0d_vec_seq", i), vok, 1);
            chk($sformatf("v%0d_done_pulse", i), pok, 1);
            chk($sformatf("v%0d_table", i), table_out, tv[i].tab);
            chk($sformatf("v%0d_mismatch", i), mismatch, tv[i].mism);
            chk($sformatf("v%0d_idx", i), mismatch_idx, tv[i].idx);
            chk($sformatf("v%0d_err", i), err_count, tv[i].err);
        end
        stuck = 1'b0;

        // reset mid-sweep while vector 4 is applied
        expected = 8'h00;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (vec_out !== 3'd4 && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("reach_vec4", vec_out, 4);
        chk("partial_mismatch", mismatch, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midsweep_reset", {vec_out, busy, done, table_out, mismatch, mismatch_idx, err_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // following start gives fresh results from vector 0
        run_sweep(8'hE8, -1, de, vok, pok);
        chk("fresh_done_edge", de, 17);
        chk("fresh_vec_seq", vok, 1);
        chk("fresh_table", table_out, 8'hE8);
        chk("fresh_err", {mismatch, err_count}, 0);

        // start held high: ignored during the sweep, restarts on the first IDLE cycle
        expected = 8'hE8;
        start    = 1'b1;
        @(posedge clk);
        de = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                de = e;
                break;
            end
        end
        chk("held_done_edge", de, 17);
        @(posedge clk);
        #1;
        chk("held_restart", {busy, vec_out}, {1'b1, 3'd0});
        start = 1'b0;
        guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("held_second_done", done, 1);
        chk("held_second_table", table_out, 8'hE8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
